// File: rtl/par_local_inject_arbiter.sv
// Round-robin arbiter sharing one router local injection port between N_REQ requesters.
// Single-entry registered output stage with valid/busy handshakes on both sides.

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 24
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif

module par_local_inject_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DATA_W = `PAYLOAD_SIZE + `ADDR_BITS,
  parameter int unsigned CNT_W  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_busy,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_busy,
  output logic [ID_W-1:0]         grant_id,
  output logic [CNT_W-1:0]        pkt_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                can_load;
  logic                any_req;
  logic                grant;
  logic [ID_W-1:0]     winner;
  logic [DATA_W-1:0]   win_data;

  assign can_load = !reset && enable && ((state_q == EMPTY) || !out_busy);
  assign any_req  = |req_valid;
  assign grant    = can_load && any_req;

  // Scan offsets from farthest to nearest so the nearest valid requester after rr_q wins.
  always_comb begin
    int unsigned idx;
    winner = '0;
    idx    = 0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if ((i == idx) && req_valid[i]) winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    req_busy = '1;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_busy[i] = !(grant && (winner == ID_W'(i)));
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (grant) begin
      state_d = FULL;
      data_d  = win_data;
      gid_d   = winner;
      rr_d    = winner;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if ((state_q == FULL) && !out_busy) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      gid_q   <= '0;
      rr_q    <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign grant_id  = gid_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_par_local_inject_arbiter.sv
// Directed bench for par_local_inject_arbiter: main 4-requester instance plus a CNT_W=4
// instance for counter wrap.

module tb_par_local_inject_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_busy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_busy;
  logic [1:0]    grant_id;
  logic [19:0]   pkt_count;

  logic [3:0]    req_valid4;
  logic [4*DW-1:0] req_data4;
  logic [3:0]    req_busy4;
  logic [DW-1:0] out_data4;
  logic          out_valid4;
  logic          out_busy4;
  logic [1:0]    grant_id4;
  logic [3:0]    pkt_count4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  par_local_inject_arbiter #(.N_REQ(4), .ID_W(2), .DATA_W(DW), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_busy(req_busy), .out_data(out_data), .out_valid(out_valid), .out_busy(out_busy),
    .grant_id(grant_id), .pkt_count(pkt_count)
  );

  par_local_inject_arbiter #(.N_REQ(4), .ID_W(2), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid4), .req_data(req_data4),
    .req_busy(req_busy4), .out_data(out_data4), .out_valid(out_valid4), .out_busy(out_busy4),
    .grant_id(grant_id4), .pkt_count(pkt_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_all_data();
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 16'hB000 + 16'(i << 4);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; out_busy = 1'b0; req_valid = '0; req_data = '0;
    out_busy4 = 1'b0; req_valid4 = '0; req_data4 = '0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", out_data); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
    total++; if (pkt_count !== 20'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", pkt_count); end
    req_valid = 4'hF;
    #1;
    total++; if (req_busy !== 4'hF) begin bad++; $display("FAIL rst_busy got=%b exp=1111", req_busy); end
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    for (int n = 1; n <= 4; n++) begin
      req_data[0 +: DW] = 16'hA000 + 16'(n);
      #1;
      total++; if (req_busy !== 4'b1110) begin bad++; $display("FAIL t1_busy n=%0d got=%b exp=1110", n, req_busy); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t1_valid n=%0d got=%b exp=1", n, out_valid); end
      total++; if (out_data !== 16'hA000 + 16'(n)) begin bad++; $display("FAIL t1_data n=%0d got=%h exp=%h", n, out_data, 16'hA000 + 16'(n)); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL t1_gid n=%0d got=%0d exp=0", n, grant_id); end
      total++; if (pkt_count !== 20'(n)) begin bad++; $display("FAIL t1_cnt got=%0d exp=%0d", pkt_count, n); end
    end
    req_valid = '0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    do_reset();
    set_all_data();
    req_valid = 4'hF;
    for (int n = 1; n <= 6; n++) begin
      g = 2'((n - 1) % 4);
      #1;
      total++; if (req_busy !== ~(4'b0001 << g)) begin bad++; $display("FAIL t2_busy n=%0d got=%b exp=%b", n, req_busy, ~(4'b0001 << g)); end
      tick();
      total++; if (grant_id !== g) begin bad++; $display("FAIL t2_gid n=%0d got=%0d exp=%0d", n, grant_id, g); end
      total++; if (out_data !== 16'hB000 + 16'(g << 4)) begin bad++; $display("FAIL t2_data n=%0d got=%h exp=%h", n, out_data, 16'hB000 + 16'(g << 4)); end
      total++; if (pkt_count !== 20'(n)) begin bad++; $display("FAIL t2_cnt got=%0d exp=%0d", pkt_count, n); end
    end
  endtask

  task automatic test_backpressure();
    out_busy = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      total++; if (req_busy !== 4'hF) begin bad++; $display("FAIL t3_busy got=%b exp=1111", req_busy); end
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 16'hB010 || grant_id !== 2'd1) begin
        bad++; $display("FAIL t3_hold got=%b/%h/%0d exp=1/b010/1", out_valid, out_data, grant_id); end
      total++; if (pkt_count !== 20'd6) begin bad++; $display("FAIL t3_cnt got=%0d exp=6", pkt_count); end
    end
    out_busy = 1'b0;
    #1;
    total++; if (req_busy !== 4'b1011) begin bad++; $display("FAIL t3_rel_busy got=%b exp=1011", req_busy); end
    tick();
    total++; if (grant_id !== 2'd2 || out_data !== 16'hB020) begin bad++; $display("FAIL t3_next got=%0d/%h exp=2/b020", grant_id, out_data); end
    total++; if (pkt_count !== 20'd7) begin bad++; $display("FAIL t3_cnt2 got=%0d exp=7", pkt_count); end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    #1;
    total++; if (req_busy !== 4'hF) begin bad++; $display("FAIL t4_busy got=%b exp=1111", req_busy); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t4_drain got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0 || pkt_count !== 20'd7) begin bad++; $display("FAIL t4_idle got=%b/%0d exp=0/7", out_valid, pkt_count); end
    enable = 1'b1;
    #1;
    total++; if (req_busy !== 4'b0111) begin bad++; $display("FAIL t4_resume_busy got=%b exp=0111", req_busy); end
    tick();
    total++; if (grant_id !== 2'd3 || out_data !== 16'hB030 || pkt_count !== 20'd8) begin
      bad++; $display("FAIL t4_resume got=%0d/%h/%0d exp=3/b030/8", grant_id, out_data, pkt_count); end
  endtask

  task automatic test_mid_reset();
    out_busy = 1'b1;
    reset = 1'b1;
    #1;
    total++; if (req_busy !== 4'hF) begin bad++; $display("FAIL t5_busy got=%b exp=1111", req_busy); end
    tick();
    total++; if (out_valid !== 1'b0 || pkt_count !== 20'd0 || out_data !== 16'h0 || grant_id !== 2'd0) begin
      bad++; $display("FAIL t5_rst got=%b/%0d/%h/%0d exp=0/0/0/0", out_valid, pkt_count, out_data, grant_id); end
    reset = 1'b0;
    out_busy = 1'b0;
    #1;
    total++; if (req_busy !== 4'b1110) begin bad++; $display("FAIL t5_first_busy got=%b exp=1110", req_busy); end
    tick();
    total++; if (grant_id !== 2'd0 || out_data !== 16'hB000 || pkt_count !== 20'd1) begin
      bad++; $display("FAIL t5_first got=%0d/%h/%0d exp=0/b000/1", grant_id, out_data, pkt_count); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wrap();
    req_valid4 = 4'b0001;
    for (int n = 1; n <= 17; n++) begin
      req_data4[0 +: DW] = 16'h0100 + 16'(n);
      tick();
      total++; if (pkt_count4 !== 4'(n % 16)) begin bad++; $display("FAIL t6_cnt n=%0d got=%0d exp=%0d", n, pkt_count4, n % 16); end
      total++; if (out_valid4 !== 1'b1 || out_data4 !== 16'h0100 + 16'(n)) begin
        bad++; $display("FAIL t6_data n=%0d got=%b/%h exp=1/%h", n, out_valid4, out_data4, 16'h0100 + 16'(n)); end
    end
    req_valid4 = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
